ts_sched_ctrl: RTL and testbench

- Timing-slice scheduler that generates the `ts` strobe consumed by the traffic-sequence `fsm`, timed from `clkin`.
- Produces a programmable high/low duty pattern (default 5 high, 1 low), so the FSM no longer depends on a bench-driven `ts`.
- Also conditions the raw `sensor` input (synchroniser plus debounce) before it reaches the FSM.
- Sits between the board inputs and `fsm`; all outputs are registered in the `clkin` domain.

---
 rtl/ts_sched_pkg.sv | 15 +
 rtl/sensor_debounce.sv | 47 ++++
 rtl/ts_sched_ctrl.sv | 137 +++++++++++++
 tb/tb_ts_sched_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ts_sched_pkg.sv
// Shared definitions for the time-slice scheduler: state encoding and the
// power-up defaults for the slice lengths and sensor debounce depth.
package ts_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_t;

  localparam int HIGH_DEF_C = 5;
  localparam int LOW_DEF_C  = 1;
  localparam int DEB_LEN_C  = 4;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stable-sample debouncer; the output only
// follows the input after DEB_LEN consecutive differing synchronised samples.
module sensor_debounce #(
  parameter int DEB_LEN = ts_sched_pkg::DEB_LEN_C
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_clean
);

  localparam int CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DEB_LEN - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_clean;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample that agrees with the current output restarts the stability count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_clean) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST_CNT) begin
      r_clean <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/ts_sched_ctrl.sv
// Time-slice scheduler: generates the ts high/low pattern for the traffic FSM
// and conditions the raw sensor input; all outputs come straight from flops.
module ts_sched_ctrl #(
  parameter int CNT_W    = 8,
  parameter int HIGH_DEF = ts_sched_pkg::HIGH_DEF_C,
  parameter int LOW_DEF  = ts_sched_pkg::LOW_DEF_C,
  parameter int DEB_LEN  = ts_sched_pkg::DEB_LEN_C
) (
  input  logic             i_clkin,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_cfg_load,
  input  logic [CNT_W-1:0] i_cfg_high,
  input  logic [CNT_W-1:0] i_cfg_low,
  input  logic             i_sensor_raw,
  output logic             o_ts,
  output logic             o_sensor,
  output logic             o_period_done,
  output logic             o_busy
);

  import ts_sched_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pendHigh;
  logic [CNT_W-1:0] r_pendLow;
  logic [CNT_W-1:0] r_actHigh;
  logic [CNT_W-1:0] r_actLow;
  logic             r_ts;
  logic             r_periodDone;
  logic             r_busy;

  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_reload;
  logic [CNT_W-1:0] w_cfgHighClamp;
  logic [CNT_W-1:0] w_cfgLowClamp;
  logic [CNT_W-1:0] w_pendHighEff;
  logic [CNT_W-1:0] w_pendLowEff;

  // A zero length would underflow the down-counter, so it is stored as 1.
  assign w_cfgHighClamp = (i_cfg_high == '0) ? CNT_W'(1) : i_cfg_high;
  assign w_cfgLowClamp  = (i_cfg_low  == '0) ? CNT_W'(1) : i_cfg_low;

  // A load coinciding with a boundary reload wins over the stored pending value.
  assign w_pendHighEff = i_cfg_load ? w_cfgHighClamp : r_pendHigh;
  assign w_pendLowEff  = i_cfg_load ? w_cfgLowClamp  : r_pendLow;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_reload    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_enable) begin
          w_nextState = HIGH;
          w_reload    = 1'b1;
          w_nextCnt   = w_pendHighEff - CNT_W'(1);
        end
      end
      HIGH: begin
        if (r_cnt == '0) begin
          w_nextState = LOW;
          w_nextCnt   = r_actLow - CNT_W'(1);
        end else begin
          w_nextCnt = r_cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (r_cnt == '0) begin
          if (i_enable) begin
            w_nextState = HIGH;
            w_reload    = 1'b1;
            w_nextCnt   = w_pendHighEff - CNT_W'(1);
          end else begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
          end
        end else begin
          w_nextCnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge i_clkin or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pendHigh   <= CNT_W'(HIGH_DEF);
      r_pendLow    <= CNT_W'(LOW_DEF);
      r_actHigh    <= CNT_W'(HIGH_DEF);
      r_actLow     <= CNT_W'(LOW_DEF);
      r_ts         <= 1'b0;
      r_periodDone <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_cnt        <= w_nextCnt;
      r_ts         <= (w_nextState == HIGH);
      r_periodDone <= (w_nextState == LOW) && (w_nextCnt == '0);
      r_busy       <= (w_nextState != IDLE);
      if (i_cfg_load) begin
        r_pendHigh <= w_cfgHighClamp;
        r_pendLow  <= w_cfgLowClamp;
      end
      if (w_reload) begin
        r_actHigh <= w_pendHighEff;
        r_actLow  <= w_pendLowEff;
      end
    end
  end

  sensor_debounce #(
    .DEB_LEN(DEB_LEN)
  ) u_sensorDebounce (
    .i_clk  (i_clkin),
    .i_reset(i_reset),
    .i_raw  (i_sensor_raw),
    .o_clean(o_sensor)
  );

  assign o_ts          = r_ts;
  assign o_period_done = r_periodDone;
  assign o_busy        = r_busy;

  // Active high length is only reloaded here; the HIGH count itself is seeded from pending.
  logic w_unusedActHigh;
  assign w_unusedActHigh = ^r_actHigh;

endmodule

// File: tb/tb_ts_sched_ctrl.sv
// Directed self-checking bench for ts_sched_ctrl: duty pattern, config reload,
// clamping, graceful stop, sensor debounce and asynchronous reset.
module tb_ts_sched_ctrl;

  logic       clkin;
  logic       reset;
  logic       enable;
  logic       cfgLoad;
  logic [7:0] cfgHigh;
  logic [7:0] cfgLow;
  logic       sensorRaw;
  logic       ts;
  logic       sensor;
  logic       periodDone;
  logic       busy;

  int checkCount = 0;
  int passCount  = 0;

  ts_sched_ctrl #(
    .CNT_W   (8),
    .HIGH_DEF(5),
    .LOW_DEF (1),
    .DEB_LEN (4)
  ) dut (
    .i_clkin      (clkin),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_cfg_load   (cfgLoad),
    .i_cfg_high   (cfgHigh),
    .i_cfg_low    (cfgLow),
    .i_sensor_raw (sensorRaw),
    .o_ts         (ts),
    .o_sensor     (sensor),
    .o_period_done(periodDone),
    .o_busy       (busy)
  );

  // 50 ns clkin
  initial clkin = 1'b0;
  always #25 clkin = ~clkin;

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic [7:0] hi, input logic [7:0] lo);
    enable  = en;
    cfgLoad = ld;
    cfgHigh = hi;
    cfgLow  = lo;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic stepCycles(input int n);
    repeat (n) @(negedge clkin);
  endtask

  initial begin
    logic [11:0] expTs1, expPd1;
    logic [15:0] expTs2, expPd2;
    logic [6:0]  expTs4, expPd4, expBusy4;
    logic [7:0]  expTs3, expPd3;
    logic [3:0]  expTsB, expPdB;
    logic [9:0]  expSens;
    logic [5:0]  expTsR, expPdR;
    logic        found;

    reset     = 1'b1;
    sensorRaw = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0);

    stepCycles(2);
    checkOutput("rstTs", ts, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstPd", periodDone, 1'b0);
    checkOutput("rstSensor", sensor, 1'b0);
    reset = 1'b0;
    stepCycles(1);
    checkOutput("idleTs", ts, 1'b0);
    checkOutput("idleBusy", busy, 1'b0);

    $display("[TB] default 5/1 pattern");
    expTs1 = 12'b111110_111110;
    expPd1 = 12'b000001_000001;
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 12; i++) begin
      stepCycles(1);
      checkOutput($sformatf("defTs[%0d]", i), ts, expTs1[11-i]);
      checkOutput($sformatf("defPd[%0d]", i), periodDone, expPd1[11-i]);
      checkOutput($sformatf("defBusy[%0d]", i), busy, 1'b1);
    end

    $display("[TB] load 3/2 during HIGH");
    expTs2 = 16'b111110_11100_11100;
    expPd2 = 16'b000001_00001_00001;
    for (int i = 0; i < 16; i++) begin
      stepCycles(1);
      checkOutput($sformatf("cfgTs[%0d]", i), ts, expTs2[15-i]);
      checkOutput($sformatf("cfgPd[%0d]", i), periodDone, expPd2[15-i]);
      if (i == 0) applyStimulus(1'b1, 1'b1, 8'd3, 8'd2);
      if (i == 1) applyStimulus(1'b1, 1'b0, 8'd3, 8'd2);
    end

    $display("[TB] graceful stop");
    expTs4   = 7'b1110000;
    expPd4   = 7'b0000100;
    expBusy4 = 7'b1111100;
    for (int i = 0; i < 7; i++) begin
      stepCycles(1);
      checkOutput($sformatf("stopTs[%0d]", i), ts, expTs4[6-i]);
      checkOutput($sformatf("stopPd[%0d]", i), periodDone, expPd4[6-i]);
      checkOutput($sformatf("stopBusy[%0d]", i), busy, expBusy4[6-i]);
      if (i == 1) applyStimulus(1'b0, 1'b0, 8'd3, 8'd2);
    end
    applyStimulus(1'b1, 1'b0, 8'd3, 8'd2);
    stepCycles(1);
    checkOutput("reenTs", ts, 1'b1);
    checkOutput("reenBusy", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd3, 8'd2);
    stepCycles(5);
    checkOutput("reIdleTs", ts, 1'b0);
    checkOutput("reIdleBusy", busy, 1'b0);

    $display("[TB] zero lengths clamp to 1/1");
    applyStimulus(1'b0, 1'b1, 8'd0, 8'd0);
    stepCycles(1);
    checkOutput("clampIdleBusy", busy, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'd0);
    expTs3 = 8'b10101010;
    expPd3 = 8'b01010101;
    for (int i = 0; i < 8; i++) begin
      stepCycles(1);
      checkOutput($sformatf("clampTs[%0d]", i), ts, expTs3[7-i]);
      checkOutput($sformatf("clampPd[%0d]", i), periodDone, expPd3[7-i]);
    end

    $display("[TB] load on boundary cycle");
    applyStimulus(1'b1, 1'b1, 8'd2, 8'd1);
    expTsB = 4'b1101;
    expPdB = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      stepCycles(1);
      checkOutput($sformatf("bndTs[%0d]", i), ts, expTsB[3-i]);
      checkOutput($sformatf("bndPd[%0d]", i), periodDone, expPdB[3-i]);
      if (i == 0) applyStimulus(1'b1, 1'b0, 8'd2, 8'd1);
    end

    $display("[TB] sensor debounce");
    sensorRaw = 1'b1;
    stepCycles(8);
    checkOutput("sensRise", sensor, 1'b1);
    sensorRaw = 1'b0;
    stepCycles(2);
    sensorRaw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stepCycles(1);
      checkOutput($sformatf("glitch[%0d]", i), sensor, 1'b1);
    end
    sensorRaw = 1'b0;
    expSens = 10'b1111100000;
    for (int i = 0; i < 10; i++) begin
      stepCycles(1);
      checkOutput($sformatf("sensFall[%0d]", i + 1), sensor, expSens[9-i]);
    end
    sensorRaw = 1'b1;
    stepCycles(8);
    checkOutput("sensHigh", sensor, 1'b1);

    $display("[TB] async reset mid-LOW");
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      stepCycles(1);
      if (periodDone) found = 1'b1;
    end
    checkOutput("reachLow", found, 1'b1);
    #5 reset = 1'b1;
    #1;
    checkOutput("arstTs", ts, 1'b0);
    checkOutput("arstBusy", busy, 1'b0);
    checkOutput("arstSensor", sensor, 1'b0);
    checkOutput("arstPd", periodDone, 1'b0);
    stepCycles(2);
    checkOutput("heldTs", ts, 1'b0);
    checkOutput("heldBusy", busy, 1'b0);
    reset = 1'b0;
    expTsR = 6'b111110;
    expPdR = 6'b000001;
    for (int i = 0; i < 6; i++) begin
      stepCycles(1);
      checkOutput($sformatf("postTs[%0d]", i), ts, expTsR[5-i]);
      checkOutput($sformatf("postPd[%0d]", i), periodDone, expPdR[5-i]);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
